// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: accepts one lw/lbu/sw/sb request from execute, runs a
// valid/ready transaction on the data bus and hands the result to writeback.
module ysyx_25020047_lsu #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] inst_type,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] memdata,
   output logic [31:0] out_inst_type,
   output logic        out_err
);

   localparam logic [31:0] LP_LW  = 32'h20;
   localparam logic [31:0] LP_LBU = 32'h40;
   localparam logic [31:0] LP_SW  = 32'h80;
   localparam logic [31:0] LP_SB  = 32'h100;
   localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [1:0]  r_off;
   logic        r_in_ready;
   logic        r_mem_req_valid;
   logic        r_mem_wen;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wmask;
   logic        r_out_valid;
   logic [31:0] r_memdata;
   logic [31:0] r_out_inst_type;
   logic        r_out_err;

   logic        w_in_lw, w_in_lbu, w_in_sw, w_in_sb, w_in_mem, w_in_misal;
   logic [31:0] w_rshift;

   assign w_in_lw    = (inst_type == LP_LW);
   assign w_in_lbu   = (inst_type == LP_LBU);
   assign w_in_sw    = (inst_type == LP_SW);
   assign w_in_sb    = (inst_type == LP_SB);
   assign w_in_mem   = w_in_lw | w_in_lbu | w_in_sw | w_in_sb;
   assign w_in_misal = (w_in_lw | w_in_sw) & (addr[1:0] != 2'b00);
   assign w_rshift   = mem_rdata >> {r_off, 3'b000};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_off           <= '0;
         r_in_ready      <= 1'b1;
         r_mem_req_valid <= 1'b0;
         r_mem_wen       <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_wdata     <= '0;
         r_mem_wmask     <= '0;
         r_out_valid     <= 1'b0;
         r_memdata       <= '0;
         r_out_inst_type <= '0;
         r_out_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_out_inst_type <= inst_type;
                  r_off           <= addr[1:0];
                  r_in_ready      <= 1'b0;
                  r_memdata       <= '0;
                  r_out_err       <= 1'b0;
                  if (!w_in_mem || w_in_misal) begin
                     r_out_err   <= w_in_misal;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_mem_req_valid <= 1'b1;
                     r_mem_addr      <= {addr[31:2], 2'b00};
                     r_mem_wen       <= w_in_sw | w_in_sb;
                     r_mem_wdata     <= w_in_sw ? st_data :
                                        w_in_sb ? {4{st_data[7:0]}} : '0;
                     r_mem_wmask     <= w_in_sw ? 4'b1111 :
                                        w_in_sb ? (4'b0001 << addr[1:0]) : 4'b0000;
                     r_state         <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_cnt           <= '0;
                  r_state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A response on the final counted cycle beats the timeout.
               if (mem_resp_valid) begin
                  if (r_out_inst_type == LP_LW)
                     r_memdata <= mem_rdata;
                  else if (r_out_inst_type == LP_LBU)
                     r_memdata <= {24'b0, w_rshift[7:0]};
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_cnt == LP_LAST) begin
                  r_out_err   <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign mem_req_valid = r_mem_req_valid;
   assign mem_wen       = r_mem_wen;
   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign mem_wmask     = r_mem_wmask;
   assign out_valid     = r_out_valid;
   assign memdata       = r_memdata;
   assign out_inst_type = r_out_inst_type;
   assign out_err       = r_out_err;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Bench for ysyx_25020047_lsu: directed corner cases plus randomized
// transactions scored against a transaction-level model.
module tb_ysyx_25020047_lsu;

   localparam int unsigned TO = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] inst_type;
   logic [31:0] addr;
   logic [31:0] st_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] memdata;
   logic [31:0] out_inst_type;
   logic        out_err;

   int unsigned n_checks = 0;
   int unsigned n_errs   = 0;

   ysyx_25020047_lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .inst_type(inst_type), .addr(addr), .st_data(st_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .memdata(memdata), .out_inst_type(out_inst_type), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drives one request from a negedge, answers the bus with the given
   // delays and scores everything against the model; returns at a negedge.
   task automatic run_txn(input logic [31:0] t, input logic [31:0] a, input logic [31:0] st,
                          input logic [31:0] rd, input int unsigned rdy_dly,
                          input int unsigned resp_dly, input int unsigned out_dly);
      bit          is_ld, is_st, is_mem, misal, taken;
      int unsigned off;
      logic [31:0] e_data, e_wdata;
      logic [31:0] e_mask;
      logic        e_err;

      off    = a % 4;
      is_ld  = (t == 32'h20) || (t == 32'h40);
      is_st  = (t == 32'h80) || (t == 32'h100);
      is_mem = is_ld || is_st;
      misal  = ((t == 32'h20) || (t == 32'h80)) && (off != 0);
      e_wdata = (t == 32'h80) ? st : (st & 32'hFF) * 32'h0101_0101;
      e_mask  = (t == 32'h80) ? 32'hF : (t == 32'h100) ? (32'd1 << off) : 32'd0;
      e_data = 0;
      e_err  = 0;
      taken  = 0;

      check("in_ready_idle", {31'b0, in_ready}, 1);
      in_valid  = 1'b1;
      inst_type = t;
      addr      = a;
      st_data   = st;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      inst_type = $urandom;
      addr      = $urandom;
      st_data   = $urandom;

      if (!is_mem || misal) begin
         e_err = misal;
      end else begin
         for (int unsigned i = 0; i <= rdy_dly; i++) begin
            check("req_valid", {31'b0, mem_req_valid}, 1);
            check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            check("req_wen", {31'b0, mem_wen}, {31'b0, is_st});
            check("req_wmask", {28'b0, mem_wmask}, e_mask);
            if (is_st) check("req_wdata", mem_wdata, e_wdata);
            check("out_valid_req", {31'b0, out_valid}, 0);
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_rdata      = $urandom;
            mem_req_ready  = (i == rdy_dly);
            @(posedge clk);
            @(negedge clk);
         end
         mem_req_ready = 1'b0;
         for (int unsigned w = 1; w <= TO; w++) begin
            check("req_valid_wait", {31'b0, mem_req_valid}, 0);
            check("out_valid_wait", {31'b0, out_valid}, 0);
            mem_resp_valid = (w == resp_dly + 1);
            mem_rdata      = (w == resp_dly + 1) ? rd : $urandom;
            @(posedge clk);
            @(negedge clk);
            if (w == resp_dly + 1) begin
               taken = 1;
               break;
            end
         end
         mem_resp_valid = 1'b0;
         e_err = !taken;
         if (taken && t == 32'h20) e_data = rd;
         if (taken && t == 32'h40) e_data = (rd >> (8 * off)) & 32'hFF;
      end

      for (int unsigned i = 0; i <= out_dly; i++) begin
         check("out_valid", {31'b0, out_valid}, 1);
         check("memdata", memdata, e_data);
         check("out_err", {31'b0, out_err}, {31'b0, e_err});
         check("out_inst_type", out_inst_type, t);
         check("req_valid_done", {31'b0, mem_req_valid}, 0);
         out_ready = (i == out_dly);
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("out_valid_after", {31'b0, out_valid}, 0);
      check("in_ready_after", {31'b0, in_ready}, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, {31'b0, in_ready}, 1);
      check({tag, "_out_valid"}, {31'b0, out_valid}, 0);
      check({tag, "_req_valid"}, {31'b0, mem_req_valid}, 0);
      check({tag, "_wen"}, {31'b0, mem_wen}, 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_wdata"}, mem_wdata, 0);
      check({tag, "_wmask"}, {28'b0, mem_wmask}, 0);
      check({tag, "_memdata"}, memdata, 0);
      check({tag, "_type"}, out_inst_type, 0);
      check({tag, "_err"}, {31'b0, out_err}, 0);
   endtask

   task automatic reset_mid_wait();
      in_valid  = 1'b1;
      inst_type = 32'h20;
      addr      = 32'h8000_0010;
      @(posedge clk);
      @(negedge clk);
      in_valid      = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("rst_in_wait_req", {31'b0, mem_req_valid}, 0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("rst_mid");
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'hCAFE_F00D;
      @(posedge clk);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      check("late_resp_out_valid", {31'b0, out_valid}, 0);
      check("late_resp_in_ready", {31'b0, in_ready}, 1);
      check("late_resp_memdata", memdata, 0);
   endtask

   initial begin
      logic [31:0] types [5];
      logic [31:0] t;
      types[0] = 32'h20; types[1] = 32'h40; types[2] = 32'h80; types[3] = 32'h100;
      types[4] = 32'h1;

      rst_n = 1'b0; in_valid = 1'b0; inst_type = '0; addr = '0; st_data = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("reset");

      run_txn(32'h20,  32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
      run_txn(32'h40,  32'h8000_0003, 32'h0, 32'hA1B2_C3D4, 0, 0, 0);
      run_txn(32'h40,  32'h8000_0001, 32'h0, 32'hA1B2_C3D4, 1, 1, 1);
      run_txn(32'h100, 32'h8000_0002, 32'h1234_5678, 32'h5555_AAAA, 3, 0, 0);
      run_txn(32'h80,  32'h8000_0000, 32'h0BAD_F00D, 32'h0, 0, 2, 0);
      run_txn(32'h80,  32'h8000_0001, 32'h1111_2222, 32'h0, 0, 0, 0);
      run_txn(32'h20,  32'h8000_0002, 32'h0, 32'h0, 0, 0, 0);
      run_txn(32'h0,   32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);
      run_txn(32'h20,  32'h8000_0008, 32'h0, 32'h1357_9BDF, 0, TO, 0);
      run_txn(32'h20,  32'h8000_000C, 32'h0, 32'h2468_ACE0, 0, TO - 1, 5);
      run_txn(32'h20,  32'h8000_0004, 32'h0, 32'h0, 2, TO + 1, 5);

      reset_mid_wait();

      for (int i = 0; i < 300; i++) begin
         t = types[$urandom_range(0, 4)];
         if (t == 32'h1) t = $urandom;
         run_txn(t, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/ysyx_25020047_lsu.md
Name: ysyx_25020047_lsu

Overview:
- Load/store unit sitting directly upstream of the writeback stage.
- Takes the one-hot instruction type, the effective address (EXU result) and the store data from execute.
- Runs a multi-cycle valid/ready transaction on the data-memory bus.
- Presents the load data to writeback as memdata, held under a valid/ready handshake.

Parameters:
TIMEOUT, 256, maximum WAIT cycles before a response is declared lost; legal range 1..65535.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  execute has a request
in_ready  output  1  LSU can accept a request
inst_type  input  32  one-hot type: 32'h20 lw, 32'h40 lbu, 32'h80 sw, 32'h100 sb; any other value = non-memory
addr  input  32  effective address
st_data  input  32  rs2 value for stores
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_wen  output  1  1 = write, 0 = read
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  output  32  write data
mem_wmask  output  4  byte-lane write strobes
mem_resp_valid  input  1  read data / write acknowledge valid
mem_rdata  input  32  read data
out_valid  output  1  result valid to writeback
out_ready  input  1  writeback accepts result
memdata  output  32  load result to writeback
out_inst_type  output  32  latched inst_type passed to writeback
out_err  output  1  misaligned access or timeout

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; every output 0 except in_ready=1; counter 0.
  - Takes priority over all events, including mid-transaction.
  - In-flight memory responses arriving after reset are ignored, because IDLE ignores mem_resp_valid.
- State IDLE: in_ready=1. On in_valid, latch inst_type, addr, st_data.
  - Memory type and aligned → REQ.
    - Aligned means lw/sw with addr[1:0]==0; lbu/sb are always aligned.
  - Misaligned lw/sw → DONE with out_err=1, memdata=0, no bus activity.
  - Non-memory type → DONE with memdata=0, out_err=0.
- State REQ:
  - Outputs: mem_req_valid=1; mem_addr, mem_wen, mem_wdata, mem_wmask held stable until handshake.
  - On mem_req_ready → WAIT, counter cleared.
  - No timeout in REQ.
- Bus fields per type:
  - lw: wen=0, wmask=0.
  - lbu: wen=0, wmask=0.
  - sw: wen=1, wmask=4'b1111, wdata=st_data.
  - sb: wen=1, wmask=4'b0001<<addr[1:0], wdata={4{st_data[7:0]}}.
- State WAIT: mem_req_valid=0.
  - Response is taken no earlier than the cycle after the request handshake; a resp in the REQ handshake cycle is ignored.
  - On mem_resp_valid → DONE:
    - lw: memdata=mem_rdata.
    - lbu: memdata={24'b0, selected byte}, byte selected by addr[1:0] (00→[7:0], 11→[31:24]).
    - Stores: memdata=0.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT-1 with no response → DONE with out_err=1, memdata=0.
  - A response on that same cycle wins (no error).
- State DONE: out_valid=1; memdata, out_inst_type, out_err stable.
  - On out_ready → IDLE, out_valid=0 next cycle.
  - Back-to-back issue: a new request is accepted in IDLE no earlier than one cycle after the DONE handshake.
- Latency:
  - Non-memory / misaligned: out_valid 1 cycle after acceptance.
  - Memory op with ready=1 and 1-cycle response: out_valid 3 cycles after acceptance.
- Stores never drive a non-zero memdata; writeback ignores memdata for stores.
- out_err clears on the next acceptance.

Test Plan:
- Reset mid-WAIT (lw outstanding), release, then mem_resp_valid=1 → state IDLE, out_valid stays 0, in_ready=1.
- lw addr=0x8000_0004, mem_req_ready=1, mem_rdata=0xDEADBEEF one cycle after handshake → mem_addr=0x8000_0004, wen=0; out_valid 3 cycles after accept; memdata=0xDEADBEEF, out_err=0.
- lbu addr=0x8000_0003, mem_rdata=0x A1B2C3D4 → memdata=0x000000A1; with addr[1:0]=01 → 0x000000C3.
- sb addr=0x8000_0002, st_data=0x1234_5678, mem_req_ready low 3 cycles then high → request held stable; wmask=4'b0100, wdata=0x7878_7878; on ack out_valid=1, memdata=0.
- sw addr=0x8000_0001 → no mem_req_valid ever; next cycle out_valid=1, out_err=1; same for lw addr[1:0]=10.
- TIMEOUT=4, lw with no response → out_err=1, memdata=0 after 4 WAIT cycles.
  - Repeat with response on the 4th WAIT cycle → out_err=0.
  - Hold out_ready=0 for 5 cycles → outputs stable until the handshake.
